// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO for the E stage.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (MDOp 7-10).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul, is_div, is_mac, go;
  logic        sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, quo, rem;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
    is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
`ifdef MDU_MADD_EN
    is_mac = (MDOp >= OP_MADD) && (MDOp <= OP_MSUBU);
`else
    is_mac = 1'b0;
`endif
    go = start && (is_mul || is_div || is_mac);
  end

  // One unsigned divider serves both div and divu via sign/magnitude.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    sgn    = (op_q == OP_DIV);
    a_neg  = sgn & a_q[31];
    b_neg  = sgn & b_q[31];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    uq     = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    ur     = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    quo    = (a_neg ^ b_neg) ? -uq : uq;
    rem    = a_neg ? -ur : ur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN:  if (cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (state_q == IDLE) begin
      unique case (1'b1)
        go: begin
          a_d   = A;
          b_d   = B;
          op_d  = MDOp;
          cnt_d = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
        (MDOp == OP_MTHI): hi_d = A;
        (MDOp == OP_MTLO): lo_d = A;
        default: ;
      endcase
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        case (op_q)
          OP_MULT:  {hi_d, lo_d} = prod_s;
          OP_MULTU: {hi_d, lo_d} = prod_u;
          OP_DIV, OP_DIVU:
            if (b_q != 32'd0) begin
              hi_d = rem;
              lo_d = quo;
            end
`ifdef MDU_MADD_EN
          OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
          OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
          OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
          OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    HI   = hi_q;
    LO   = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised + directed bench for mult_div_unit against a behavioural model.
// Model tracks completion by absolute edge index, not a down-counter.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDOp;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  bit          m_busy;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  int          m_op, m_done, e;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit starts(input int op);
`ifdef MDU_MADD_EN
    return op >= 1 && op <= 4 || op >= 7 && op <= 10;
`else
    return op >= 1 && op <= 4;
`endif
  endfunction

  task automatic complete();
    int sa, sb;
    longint ps, q, r;
    logic [63:0] pu, acc;
    sa = m_a;
    sb = m_b;
    ps = longint'(sa) * longint'(sb);
    pu = {32'b0, m_a} * {32'b0, m_b};
    acc = {m_hi, m_lo};
    case (m_op)
      1: {m_hi, m_lo} = ps;
      2: {m_hi, m_lo} = pu;
      3: if (m_b != 0) begin
        q = longint'(sa) / longint'(sb);
        r = longint'(sa) % longint'(sb);
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4: if (m_b != 0) begin
        m_lo = m_a / m_b;
        m_hi = m_a % m_b;
      end
      7: {m_hi, m_lo} = acc + ps;
      8: {m_hi, m_lo} = acc + pu;
      9: {m_hi, m_lo} = acc - ps;
      10: {m_hi, m_lo} = acc - pu;
      default: ;
    endcase
  endtask

  // Advance the model over the next edge, take the edge, then compare.
  task automatic tick();
    e++;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0;
    end else if (m_busy) begin
      if (e == m_done) begin
        complete();
        m_busy = 0;
      end
    end else if (start && starts(int'(MDOp))) begin
      m_a = A; m_b = B; m_op = int'(MDOp);
      m_done = e + ((MDOp == 3 || MDOp == 4) ? DC : MC);
      m_busy = 1;
    end else if (MDOp == 5) m_hi = A;
    else if (MDOp == 6) m_lo = A;
    @(posedge clk);
    #1;
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    start = 1; MDOp = op; A = a; B = b;
    tick();
    start = 0; MDOp = 0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    MDOp = op; A = a;
    tick();
    MDOp = 0;
  endtask

  initial begin
    int n;
    e = 0; m_busy = 0; m_hi = 0; m_lo = 0; m_a = 0; m_b = 0;
    m_op = 0; m_done = 0;
    reset = 1; start = 0; MDOp = 0; A = 0; B = 0;
    tick();
    tick();
    reset = 0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    start = 1; MDOp = 1; A = 7; B = 6;
    tick();
    start = 0; MDOp = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (8) tick();
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);

    run_op(1, 32'hFFFFFFFE, 3, n);
    chk("mult_cycles", n, MC);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);
    run_op(2, 32'hFFFFFFFE, 3, n);
    chk("multu_hi", HI, 32'h00000002);
    chk("multu_lo", LO, 32'hFFFFFFFA);

    run_op(3, 32'hFFFFFFF9, 2, n);
    chk("div_cycles", n, DC);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    run_op(3, 32'h80000000, 32'hFFFFFFFF, n);
    chk("divovf_lo", LO, 32'h80000000);
    chk("divovf_hi", HI, 32'h0);

    mt(5, 32'h11);
    mt(6, 32'h22);
    run_op(4, 100, 0, n);
    chk("div0_cycles", n, DC);
    chk("div0_hi", HI, 32'h11);
    chk("div0_lo", LO, 32'h22);

    start = 1; MDOp = 1; A = 7; B = 6;
    tick();
    MDOp = 3; A = 99; B = 99;
    tick();
    start = 0; MDOp = 0; A = 32'hDEAD; B = 1;
    n = 1;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("iso_cycles", n, MC);
    chk("iso_hi", HI, 32'h0);
    chk("iso_lo", LO, 32'h2A);

    mt(6, 32'h1234);
    chk("mtlo_lo", LO, 32'h1234);
    chk("mtlo_hi", HI, 32'h0);
    start = 1; MDOp = 1; A = 1; B = 1;
    tick();
    start = 0; MDOp = 5; A = 32'hDEAD;
    tick();
    MDOp = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    chk("mthi_busy_hi", HI, 32'h0);
    chk("mthi_busy_lo", LO, 32'h1);

`ifdef MDU_MADD_EN
    mt(5, 32'h0);
    mt(6, 32'hFFFFFFFF);
    run_op(7, 1, 1, n);
    chk("madd_hi", HI, 32'h1);
    chk("madd_lo", LO, 32'h0);
`else
    run_op(7, 1, 1, n);
    chk("madd_off_cycles", n, 0);
    chk("madd_off_lo", LO, 32'h1);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) == 0);
      MDOp  = 4'($urandom_range(0, 11));
      A = $urandom();
      B = $urandom();
      case ($urandom_range(0, 7))
        0: B = 0;
        1: B = $urandom_range(1, 9);
        2: begin A = 32'h80000000; B = 32'hFFFFFFFF; end
        3: A = $urandom_range(0, 1000);
        default: ;
      endcase
      tick();
    end
    reset = 0; start = 0; MDOp = 0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
